// File: rtl/uart_cipher_pkg.sv
// Shared state encodings, opcodes and status codes for the UART cipher bridge.
package uart_cipher_pkg;

  typedef logic [3:0] state_t;

  localparam state_t S_IDLE     = 4'd0;
  localparam state_t S_OPC      = 4'd1;
  localparam state_t S_RX_DATA  = 4'd2;
  localparam state_t S_RX_KEY   = 4'd3;
  localparam state_t S_LOAD     = 4'd4;
  localparam state_t S_HOLD     = 4'd5;
  localparam state_t S_WAIT     = 4'd6;
  localparam state_t S_TX_START = 4'd7;
  localparam state_t S_TX_WAIT  = 4'd8;
  localparam state_t S_GAP      = 4'd9;

  localparam logic [7:0] OP_ENC = 8'h01;
  localparam logic [7:0] OP_DEC = 8'h02;
  localparam logic [7:0] OP_KEY = 8'h03;

  localparam logic [7:0] ST_OK      = 8'h00;
  localparam logic [7:0] ST_BADOP   = 8'hE1;
  localparam logic [7:0] ST_TIMEOUT = 8'hE2;

endpackage

// File: rtl/byte_shift_reg.sv
// N-byte register: parallel load, or shift one byte in at the LSB end so the
// first byte shifted ends up in the MSB byte (also used MSB-first for unloading).
module byte_shift_reg #(
  parameter int N = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           shift_en,
  input  logic [7:0]     shift_in,
  input  logic           load_en,
  input  logic [8*N-1:0] load_val,
  output logic [8*N-1:0] q
);

  logic [8*N-1:0] q_q;
  logic [8*N-1:0] q_d;
  logic [8*N-1:0] shifted;

  if (N == 1) begin : g_one
    assign shifted = shift_in;
  end else begin : g_many
    assign shifted = {q_q[8*N-9:0], shift_in};
  end

  always_comb begin
    q_d = q_q;
    if (load_en)       q_d = load_val;
    else if (shift_en) q_d = shifted;
  end

  always_ff @(posedge clk) begin
    if (rst) q_q <= '0;
    else     q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/uart_cipher_bridge.sv
// Framed UART command bridge to a load/busy block cipher core: encrypt,
// decrypt, key load, receive timeout and a status byte on every response.
module uart_cipher_bridge
  import uart_cipher_pkg::*;
#(
  parameter int                     BLK_BYTES    = 16,
  parameter int                     KEY_BYTES    = 32,
  parameter logic [8*KEY_BYTES-1:0] KEY_INIT     = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0},
  parameter logic [7:0]             SYNC_BYTE    = 8'hA5,
  parameter int                     RX_TIMEOUT   = 1_000_000,
  parameter int                     TX_GAP       = 20000,
  parameter int                     LOAD_HOLDOFF = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  output logic [7:0]               tx_data,
  output logic                     tx_start,
  input  logic                     tx_busy,
  output logic                     core_load,
  output logic                     core_dec,
  output logic [8*KEY_BYTES-1:0]   core_key,
  output logic [8*BLK_BYTES-1:0]   core_data_in,
  input  logic [8*BLK_BYTES-1:0]   core_data_out,
  input  logic                     core_busy,
  output logic [3:0]               state_o
);

  localparam int RXC_W  = $clog2(KEY_BYTES > BLK_BYTES ? KEY_BYTES : BLK_BYTES) + 1;
  localparam int TO_W   = $clog2(RX_TIMEOUT) + 1;
  localparam int GAP_W  = $clog2(TX_GAP) + 1;
  localparam int HOLD_W = $clog2(LOAD_HOLDOFF) + 1;
  localparam int TXI_W  = $clog2(BLK_BYTES + 1) + 1;

  localparam logic [RXC_W-1:0]  BLK_LAST  = RXC_W'(BLK_BYTES - 1);
  localparam logic [RXC_W-1:0]  KEY_LAST  = RXC_W'(KEY_BYTES - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(RX_TIMEOUT - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(TX_GAP - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LOAD_HOLDOFF - 1);
  localparam logic [TXI_W-1:0]  TX_BLK_END = TXI_W'(BLK_BYTES);

  state_t              state_q, state_d;
  logic [RXC_W-1:0]    rx_cnt_q, rx_cnt_d;
  logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
  logic [TXI_W-1:0]    tx_idx_q, tx_idx_d;
  logic                has_blk_q, has_blk_d;
  logic                busy_seen_q, busy_seen_d;
  logic [7:0]          status_q, status_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                core_load_q, core_load_d;
  logic                core_dec_q, core_dec_d;
  logic                key_commit_q, key_commit_d;
  logic [8*KEY_BYTES-1:0] key_q, key_d;

  logic                blk_shift, key_shift, tx_load, tx_shift;
  logic                in_frame;
  logic [8*BLK_BYTES-1:0] blk_q, tx_q;
  logic [8*KEY_BYTES-1:0] shadow_q;
  logic [7:0]          tx_byte;
  logic                tx_unused;

  byte_shift_reg #(.N(BLK_BYTES)) u_blk (
    .clk(clk), .rst(rst), .shift_en(blk_shift), .shift_in(rx_data),
    .load_en(1'b0), .load_val('0), .q(blk_q)
  );

  byte_shift_reg #(.N(KEY_BYTES)) u_key_shadow (
    .clk(clk), .rst(rst), .shift_en(key_shift), .shift_in(rx_data),
    .load_en(1'b0), .load_val('0), .q(shadow_q)
  );

  byte_shift_reg #(.N(BLK_BYTES)) u_tx (
    .clk(clk), .rst(rst), .shift_en(tx_shift), .shift_in(8'h00),
    .load_en(tx_load), .load_val(core_data_out), .q(tx_q)
  );

  assign tx_byte   = tx_q[8*BLK_BYTES-1 -: 8];
  assign tx_unused = ^tx_q;
  assign in_frame  = (state_q == S_OPC) || (state_q == S_RX_DATA) || (state_q == S_RX_KEY);

  always_comb begin
    state_d      = state_q;
    rx_cnt_d     = rx_cnt_q;
    to_cnt_d     = to_cnt_q;
    hold_cnt_d   = hold_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    tx_idx_d     = tx_idx_q;
    has_blk_d    = has_blk_q;
    busy_seen_d  = busy_seen_q;
    status_d     = status_q;
    tx_data_d    = tx_data_q;
    core_dec_d   = core_dec_q;
    core_load_d  = 1'b0;
    key_commit_d = 1'b0;
    key_d        = key_commit_q ? shadow_q : key_q;
    blk_shift    = 1'b0;
    key_shift    = 1'b0;
    tx_load      = 1'b0;
    tx_shift     = 1'b0;

    case (state_q)
      S_IDLE: begin
        rx_cnt_d  = '0;
        to_cnt_d  = '0;
        tx_idx_d  = '0;
        has_blk_d = 1'b0;
        if (rx_valid && rx_data == SYNC_BYTE) state_d = S_OPC;
      end
      S_OPC: if (rx_valid) begin
        to_cnt_d = '0;
        case (rx_data)
          OP_ENC, OP_DEC: begin
            core_dec_d = (rx_data == OP_DEC);
            state_d    = S_RX_DATA;
          end
          OP_KEY:  state_d = S_RX_KEY;
          default: begin
            status_d = ST_BADOP;
            state_d  = S_TX_START;
          end
        endcase
      end
      S_RX_DATA: if (rx_valid) begin
        to_cnt_d  = '0;
        blk_shift = 1'b1;
        if (rx_cnt_q == BLK_LAST) begin
          rx_cnt_d = '0;
          state_d  = S_LOAD;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      S_RX_KEY: if (rx_valid) begin
        to_cnt_d  = '0;
        key_shift = 1'b1;
        if (rx_cnt_q == KEY_LAST) begin
          // shadow holds the full key one cycle later; commit then
          rx_cnt_d     = '0;
          key_commit_d = 1'b1;
          status_d     = ST_OK;
          state_d      = S_TX_START;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      S_LOAD: begin
        core_load_d = 1'b1;
        hold_cnt_d  = '0;
        state_d     = (LOAD_HOLDOFF == 0) ? S_WAIT : S_HOLD;
      end
      S_HOLD: begin
        if (hold_cnt_q == HOLD_LAST) state_d = S_WAIT;
        else                         hold_cnt_d = hold_cnt_q + 1'b1;
      end
      S_WAIT: if (!core_busy) begin
        tx_load   = 1'b1;
        has_blk_d = 1'b1;
        status_d  = ST_OK;
        state_d   = S_TX_START;
      end
      S_TX_START: if (!tx_busy) begin
        busy_seen_d = 1'b0;
        state_d     = S_TX_WAIT;
      end
      S_TX_WAIT: begin
        if (tx_busy) begin
          busy_seen_d = 1'b1;
        end else if (busy_seen_q) begin
          gap_cnt_d = '0;
          state_d   = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_cnt_q == GAP_LAST)
          state_d = (has_blk_q && tx_idx_q <= TX_BLK_END) ? S_TX_START : S_IDLE;
        else
          gap_cnt_d = gap_cnt_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // a byte arriving on the terminal count cycle keeps the frame alive
    if (in_frame && !rx_valid) begin
      if (to_cnt_q == TO_LAST) begin
        to_cnt_d = '0;
        status_d = ST_TIMEOUT;
        state_d  = S_TX_START;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end

    if (state_d == S_TX_START && state_q != S_TX_START) begin
      tx_idx_d = tx_idx_q + 1'b1;
      if (tx_idx_q == '0) begin
        tx_data_d = status_d;
      end else begin
        tx_data_d = tx_byte;
        tx_shift  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      rx_cnt_q     <= '0;
      to_cnt_q     <= '0;
      hold_cnt_q   <= '0;
      gap_cnt_q    <= '0;
      tx_idx_q     <= '0;
      has_blk_q    <= 1'b0;
      busy_seen_q  <= 1'b0;
      status_q     <= ST_OK;
      tx_data_q    <= 8'h00;
      core_load_q  <= 1'b0;
      core_dec_q   <= 1'b0;
      key_commit_q <= 1'b0;
      key_q        <= KEY_INIT;
    end else begin
      state_q      <= state_d;
      rx_cnt_q     <= rx_cnt_d;
      to_cnt_q     <= to_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      tx_idx_q     <= tx_idx_d;
      has_blk_q    <= has_blk_d;
      busy_seen_q  <= busy_seen_d;
      status_q     <= status_d;
      tx_data_q    <= tx_data_d;
      core_load_q  <= core_load_d;
      core_dec_q   <= core_dec_d;
      key_commit_q <= key_commit_d;
      key_q        <= key_d;
    end
  end

  assign tx_start     = (state_q == S_TX_START) && !tx_busy;
  assign tx_data      = tx_data_q;
  assign core_load    = core_load_q;
  assign core_dec     = core_dec_q;
  assign core_key     = key_q;
  assign core_data_in = blk_q;
  assign state_o      = state_q;

endmodule

// File: doc/uart_cipher_bridge.md
# uart_cipher_bridge

Parametrised UART-to-block-cipher command bridge that sits between the `async_receiver`/`async_transmitter` pair and a block cipher core with a load/busy handshake. It is the generalised successor of the fixed 16-byte echo-encrypt top level. It adds:
- framed commands (sync byte + opcode);
- runtime key loading;
- encrypt/decrypt selection;
- a receive timeout;
- a status byte on every response.

Everything runs in the `clk` domain with synchronous reset.

## Interface
Parameters:
- `BLK_BYTES`, 16: cipher block size in bytes.
- `KEY_BYTES`, 32: key register size in bytes.
- `KEY_INIT`, 256'h2b7e151628aed2a6abf7158809cf4f3c_00…0: key register value after reset.
- `SYNC_BYTE`, 8'hA5: frame start marker.
- `RX_TIMEOUT`, 1_000_000: maximum idle cycles between frame bytes before abort.
- `TX_GAP`, 20000: idle cycles inserted after each transmitted byte.
- `LOAD_HOLDOFF`, 2: cycles after `core_load` during which `core_busy` is ignored.

Ports (one clock, `clk`; reset `rst` is synchronous and active-high):
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous active-high reset.
- `rx_data`  in  8  received byte, valid when `rx_valid` is high.
- `rx_valid`  in  1  one-cycle strobe per received byte, already synchronous to `clk`.
- `tx_data`  out  8  byte to transmit.
- `tx_start`  out  1  one-cycle transmit request.
- `tx_busy`  in  1  transmitter busy.
- `core_load`  out  1  one-cycle start pulse to the cipher core.
- `core_dec`  out  1  1 = decrypt, 0 = encrypt; held stable from `core_load` until the core finishes.
- `core_key`  out  8*KEY_BYTES  key register.
- `core_data_in`  out  8*BLK_BYTES  block register.
- `core_data_out`  in  8*BLK_BYTES  cipher result.
- `core_busy`  in  1  cipher core busy.
- `state_o`  out  4  current state encoding, for LEDs and debug.

## Operation
Frame format: `SYNC_BYTE`, then an opcode byte, then the payload.

Opcodes:
- 0x01: encrypt. Payload is `BLK_BYTES` bytes.
- 0x02: decrypt. Payload is `BLK_BYTES` bytes.
- 0x03: load key. Payload is `KEY_BYTES` bytes.

Response: one status byte, followed by `BLK_BYTES` result bytes for opcodes 0x01/0x02 only. Status codes:
- 0x00: ok.
- 0xE1: unknown opcode.
- 0xE2: receive timeout.

Byte order:
- The first payload byte lands in the MSB byte (`[8*N-1 -: 8]`).
- Result bytes are sent MSB byte first.

States:
- IDLE
  - On `rx_valid` with `SYNC_BYTE` → OPC. Any other byte is discarded.
- OPC
  - 0x01/0x02: latch `core_dec`, → RX_DATA.
  - 0x03: → RX_KEY.
  - Any other opcode: status = 0xE1, → TX_START.
- RX_DATA / RX_KEY
  - Shift each byte in, counting up to `BLK_BYTES` / `KEY_BYTES`.
  - After the last byte: RX_DATA → LOAD; RX_KEY → status = 0x00, → TX_START.
  - The key register is written only once all `KEY_BYTES` bytes have arrived. The bytes are collected in a shadow register, so an aborted key load leaves the old key intact.
- LOAD
  - `core_load` = 1 for exactly one cycle, → HOLD.
- HOLD
  - Wait `LOAD_HOLDOFF` cycles, → WAIT.
- WAIT
  - When `core_busy` = 0: capture `core_data_out` into the tx shift register, status = 0x00, → TX_START.
- TX_START
  - Drive `tx_data`, pulse `tx_start`, → TX_WAIT.
- TX_WAIT
  - Wait for `tx_busy` to go 1 and then back to 0, → GAP.
- GAP
  - Count `TX_GAP` cycles.
  - If bytes remain: → TX_START.
  - Otherwise: → IDLE.
- Receive timeout: in OPC, RX_DATA or RX_KEY, the timeout counter resets on every `rx_valid`. When it reaches `RX_TIMEOUT`: status = 0xE2, → TX_START, status byte only.
- `rx_valid` outside IDLE/OPC/RX_* is ignored: no buffering, no error.

## Timing
- Reset values:
  - `tx_start` = 0, `core_load` = 0, `core_dec` = 0, `tx_data` = 0.
  - `core_data_in` = 0, `core_key` = `KEY_INIT`, `state_o` = IDLE (0).
  - All counters = 0.
- Reset mid-frame or mid-transmit aborts immediately with no partial response. An in-flight core operation is abandoned and its result is never read.
- `core_load` rises the cycle after entering LOAD, which is 2 cycles after the last payload `rx_valid`.
- The first `tx_start` comes 1 cycle after `core_busy` is sampled low in WAIT.
- `tx_start` is asserted only when `tx_busy` = 0; at most one byte is outstanding.
- Counter widths are `$clog2` of each maximum, plus one.
- `rx_valid` and the timeout terminal count in the same cycle: the byte wins and the counter resets.
- A `BLK_BYTES` = 1 block is legal; all counters must handle a terminal count of 1.

## Structure
- Package `uart_cipher_pkg`: state enum, opcode constants (`OP_ENC`, `OP_DEC`, `OP_KEY`) and status constants (`ST_OK`, `ST_BADOP`, `ST_TIMEOUT`).
- One sub-module, `byte_shift_reg #(N)`: MSB-first load-shift and unload-shift register. It is instantiated for the block, key-shadow and tx paths.

## Test plan
- A5 01 + bytes 6bc1bee22e409f96e93d7e117393172a, default key, AES-256 model core → response 00 followed by the model ciphertext; `core_load` high exactly 1 cycle; each `tx_start` separated by ≥ `TX_GAP` cycles.
- A5 03 + 32 key bytes → response 00 only. A following A5 02 with a block → the model decrypts with the new key.
- A5 7F → response E1 only; `core_load` never asserted.
- A5 01 + 5 bytes, then silence for `RX_TIMEOUT` cycles → response E2 only. The next full frame succeeds.
- A5 03 + 10 key bytes then timeout → response E2; `core_key` still equals `KEY_INIT`.
- `rst` pulsed during TX_WAIT on the 3rd result byte → no further `tx_start`; `state_o` = 0 on the next cycle. A new frame then works normally.
